// File: rtl/mgpio_master.sv
// mgpio_master: bus initiator for one mgpio register-bus responder.
//
// It accepts READ / WRITE / SET / CLEAR / TOGGLE commands on a valid/ready
// request channel. It issues single-cycle read and write transfers on the
// mgpio bus and returns the resulting data and an error flag on a
// valid/ready response channel. A read-modify-write command issues its read
// and its write in back-to-back cycles. No new command is accepted until the
// response has been consumed, so each RMW is atomic on the bus.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  command handshake (req_ready high only in IDLE)
//   req_op               0 READ, 1 WRITE, 2 SET, 3 CLEAR, 4 TOGGLE, 5-7 illegal
//   req_bank, req_reg    target bank; 0 = data register, 1 = direction register
//   req_data             write value (WRITE) or bit mask (SET/CLEAR/TOGGLE)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_err    read value or value written; command-failed flag
//   bus_addr, bus_wdata  responder address and write data
//   bus_write            write strobe, one cycle per write transfer
//   bus_rdata, bus_err   responder read data and address error (combinational)
module mgpio_master #(
    parameter int BANKS        = 1,
    parameter int BANKS_WIDTH  = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int BANK_AS_BITS = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [2:0]                          req_op,
    input  logic [BANKS_WIDTH-1:0]              req_bank,
    input  logic                                req_reg,
    input  logic [7:0]                          req_data,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [7:0]                          rsp_data,
    output logic                                rsp_err,
    output logic [BANK_AS_BITS+BANKS_WIDTH-1:0] bus_addr,
    output logic [7:0]                          bus_wdata,
    output logic                                bus_write,
    input  logic [7:0]                          bus_rdata,
    input  logic                                bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_WRITE  = 3'd1,
        OP_SET    = 3'd2,
        OP_CLEAR  = 3'd3,
        OP_TOGGLE = 3'd4
    } op_t;

    localparam int AW = BANK_AS_BITS + BANKS_WIDTH;

    // One extra bit so the limit itself is representable when BANKS is a
    // power of two (the range check then never fires, as intended).
    localparam logic [BANKS_WIDTH:0] BANK_LIMIT = (BANKS_WIDTH + 1)'(BANKS);

    state_t     state;
    op_t        op_q;
    logic [7:0] mask_q;
    logic [7:0] rmw_value;

    logic          op_legal;
    logic          bank_legal;
    logic [AW-1:0] req_addr;

    assign op_legal   = (req_op <= 3'd4);
    assign bank_legal = ({1'b0, req_bank} < BANK_LIMIT);
    assign req_addr   = {req_bank, {(BANK_AS_BITS-1){1'b0}}, req_reg};

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // The write value of a read-modify-write comes straight from the data
    // the responder returns during the RD cycle.
    always_comb begin
        // NOTE: a default before the case keeps this block purely
        // combinational; without it an uncovered op would infer a latch.
        rmw_value = bus_rdata;
        case (op_q)
            OP_SET:    rmw_value = bus_rdata | mask_q;
            OP_CLEAR:  rmw_value = bus_rdata & ~mask_q;
            OP_TOGGLE: rmw_value = bus_rdata ^ mask_q;
            default:   ;
        endcase
    end

    // Bus outputs are registered alongside the state, so they are non-zero
    // exactly while the FSM sits in RD or WR.
    // NOTE: rst is sampled only on the clock edge (synchronous reset); every
    // register, including the bus outputs, returns to its idle value here.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from pre-edge values, independent of order.
            state     <= ST_IDLE;
            op_q      <= OP_READ;
            mask_q    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!op_legal || !bank_legal) begin
                            // Rejected: answer immediately, never touch the bus.
                            state    <= ST_RESP;
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else begin
                            op_q     <= op_t'(req_op);
                            mask_q   <= req_data;
                            bus_addr <= req_addr;
                            if (op_t'(req_op) == OP_WRITE) begin
                                state     <= ST_WR;
                                bus_wdata <= req_data;
                                bus_write <= 1'b1;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (op_q == OP_READ || bus_err) begin
                        // Plain read, or an RMW whose read failed: the write
                        // is skipped and the read data is returned.
                        state    <= ST_RESP;
                        rsp_data <= bus_rdata;
                        rsp_err  <= bus_err;
                        bus_addr <= '0;
                    end else begin
                        // Address is kept so the write follows the read
                        // in the very next cycle.
                        state     <= ST_WR;
                        bus_wdata <= rmw_value;
                        bus_write <= 1'b1;
                    end
                end

                ST_WR: begin
                    state     <= ST_RESP;
                    rsp_data  <= bus_wdata;
                    rsp_err   <= bus_err;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                    bus_write <= 1'b0;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
